cam_learn_ctrl: RTL and testbench
=================================

# cam_learn_ctrl

Table-maintenance controller that sits directly upstream of the CAM core and owns its write port and lookup port. It accepts insert and delete requests over a valid/ready handshake. For each request it searches the CAM, allocates or frees an entry from a free-slot bitmap, issues the table write, and returns a one-cycle response. After every reset it clears all CAM valid bits with a sweep, because the CAM table itself has no reset.

## Interface
- `DATA_WIDTH`, default 32: key width; matches the CAM.
- `ADDR_WIDTH`, default 5: CAM index width. `ADDR_DEPTH` = 2**`ADDR_WIDTH`.

- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the controller can accept a request.
- `req_op` in 1: 0 = insert, 1 = delete.
- `req_data` in `DATA_WIDTH`: key.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_status` out 2: 00 OK, 01 EXISTS, 10 FULL, 11 NOTFOUND.
- `rsp_addr` out `ADDR_WIDTH`: CAM index associated with the response.
- `free_count` out `ADDR_WIDTH`+1: number of unallocated entries.
- `init_done` out 1: the clear sweep has completed.
- `cam_we`, `cam_addr`, `cam_data`, `cam_valid` out 1/`ADDR_WIDTH`/`DATA_WIDTH`/1: drive the CAM write port.
- `lookup_data` out `DATA_WIDTH`: CAM search key.
- `lookup_addr` in `ADDR_WIDTH`, `lookup_hit` in 1: CAM result, registered by the CAM one cycle after `lookup_data`.

## Operation
- States: INIT, IDLE, LOOK, EVAL, DONE.
- **INIT**
  - Sweep counter 0..`ADDR_DEPTH`-1, one entry per cycle.
  - Drives `cam_we`=1, `cam_addr`=counter, `cam_valid`=0, `cam_data`=0.
  - After the last index: free bitmap is all ones, `free_count`=`ADDR_DEPTH`, `init_done`=1, state goes to IDLE.
- **IDLE**
  - `req_ready`=1 only in IDLE.
  - On `req_valid` && `req_ready`: latch `req_op` and `req_data` into a key register, go to LOOK.
  - `lookup_data` is always driven from the key register.
- **LOOK**: one wait cycle while the CAM registers its compare result.
- **EVAL**: sample `lookup_hit` and `lookup_addr`, then decide:
  - Insert, hit: status EXISTS, addr = `lookup_addr`, no write.
  - Insert, miss, `free_count`≠0: status OK, addr = lowest set bit of the free bitmap, write with `cam_valid`=1 and `cam_data`=key, clear the bitmap bit.
  - Insert, miss, `free_count`=0: status FULL, addr 0, no write.
  - Delete, hit: status OK, addr = `lookup_addr`, write with `cam_valid`=0 and `cam_data`=key, set the bitmap bit.
  - Delete, miss: status NOTFOUND, addr 0, no write.
  - Decision, address and write enable are registered. Go to DONE.
- **DONE**
  - `rsp_valid`=1 with `rsp_status` and `rsp_addr`.
  - `cam_we`=1 only if a write was decided in EVAL.
  - `free_count` updates at the end of DONE.
  - Go to IDLE.
- Keys are unique by construction because an insert of an existing key returns EXISTS. The CAM's OR-combined hit address is therefore always exact.

## Timing
- Reset values (during and immediately after `reset`):
  - `req_ready`=0, `rsp_valid`=0, `rsp_status`=00, `rsp_addr`=0, `cam_we`=0, `cam_addr`=0, `cam_data`=0, `cam_valid`=0.
  - `lookup_data`=0, `init_done`=0, `free_count`=`ADDR_DEPTH`, state INIT, sweep counter 0.
- INIT:
  - The first cycle after `reset` drops writes index 0.
  - The sweep takes `ADDR_DEPTH` cycles.
  - `req_ready` first rises in cycle `ADDR_DEPTH`+1 after reset deassertion.
- Request latency: handshake at cycle T, then LOOK at T+1, EVAL at T+2, `rsp_valid` and `cam_we` at T+3.
- Throughput: the earliest next handshake is at T+4. Its LOOK cycle therefore sees the T+3 write.
- `reset` in any state aborts the operation: no `rsp_valid` and no pending write. The sweep restarts at index 0.
- Bitmap allocation is a fixed lowest-index priority encode; a freed slot is reused first if it is the lowest.

## Configuration
- `CAM_LEARN_FLUSH_EN` defined:
  - Adds input `flush` (1 bit).
  - `flush` sampled high in IDLE takes priority over `req_valid`: no handshake occurs, `init_done` goes to 0, and state goes to INIT (full sweep, bitmap reset).
  - `flush` is ignored in all other states.
- `CAM_LEARN_FLUSH_EN` undefined: the port is absent, and INIT is entered only from `reset`.

## Test plan
- Reset then release: 32 cycles of `cam_we`=1 with `cam_addr` 0..31 and `cam_valid`=0; then `req_ready`=1, `init_done`=1, `free_count`=32.
- Insert 0xDEADBEEF at cycle T: `rsp_valid` at T+3 with OK, addr 0, `cam_we`=1, `cam_valid`=1, `free_count`=31. Repeating the same insert returns EXISTS, addr 0, with no `cam_we`.
- 32 distinct inserts, then a 33rd distinct insert: responses OK with addr 0..31, then FULL with addr 0, no `cam_we`, `free_count`=0.
- From the full table, delete the key at addr 5 (OK, addr 5, `cam_valid`=0, `free_count`=1), then insert a new key: OK, addr 5.
- Delete an absent key: NOTFOUND, addr 0, no `cam_we`, `free_count` unchanged.
- `reset` asserted during EVAL: no `rsp_valid`, and the sweep restarts at addr 0.
- With `CAM_LEARN_FLUSH_EN`, `flush` and `req_valid` both high in IDLE: no handshake, a 32-cycle sweep runs, and `free_count` returns to 32.

Source files
------------

// File: rtl/cam_learn_ctrl.sv
// cam_learn_ctrl: insert/delete maintenance controller in front of a CAM core.
// Accepts requests over valid/ready. It searches the CAM, allocates or frees a
// slot from a free bitmap, issues the table write and returns a one-cycle response.
// After reset it sweeps all CAM valid bits to zero, because the table has no reset.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake; req_op 0=insert 1=delete; req_data key
//   rsp_valid/status/addr one-cycle response (00 OK, 01 EXISTS, 10 FULL, 11 NOTFOUND)
//   free_count, init_done unallocated entry count; clear sweep completed
//   cam_we/addr/data/valid CAM write port
//   lookup_data           CAM search key (registered key)
//   lookup_hit/addr       CAM result, one cycle after lookup_data
//   flush                 only with CAM_LEARN_FLUSH_EN: re-run the sweep from IDLE
//
// Build option: define CAM_LEARN_FLUSH_EN to add the flush input.
module cam_learn_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef CAM_LEARN_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  output logic [1:0]            rsp_status,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [ADDR_WIDTH:0]   free_count,
  output logic                  init_done,
  output logic                  cam_we,
  output logic [ADDR_WIDTH-1:0] cam_addr,
  output logic [DATA_WIDTH-1:0] cam_data,
  output logic                  cam_valid,
  output logic [DATA_WIDTH-1:0] lookup_data,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  input  logic                  lookup_hit
);

  localparam int unsigned ADDR_DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] StatusOk       = 2'b00;
  localparam logic [1:0] StatusExists   = 2'b01;
  localparam logic [1:0] StatusFull     = 2'b10;
  localparam logic [1:0] StatusNotFound = 2'b11;

  typedef enum logic [2:0] {StInit, StIdle, StLook, StEval, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   sweep_q;
  logic [ADDR_DEPTH-1:0]   free_q;
  logic [ADDR_WIDTH:0]     free_count_q;
  logic                    init_done_q;
  logic [DATA_WIDTH-1:0]   key_q;
  logic                    op_q;
  logic [1:0]              status_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic                    wvalid_q;
  logic [ADDR_WIDTH-1:0]   alloc_addr;
  logic                    flush_req;

`ifdef CAM_LEARN_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Lowest-index free slot; scanning downward lets the lowest set bit win.
  always_comb begin
    alloc_addr = '0;
    for (int i = ADDR_DEPTH - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_addr = ADDR_WIDTH'(i);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StInit;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit: if (&sweep_q) state_d = StIdle;
      StIdle: begin
        if (flush_req)      state_d = StInit;
        else if (req_valid) state_d = StLook;
      end
      StLook: state_d = StEval;
      StEval: state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sweep_q      <= '0;
      free_q       <= '1;
      free_count_q <= (ADDR_WIDTH + 1)'(ADDR_DEPTH);
      init_done_q  <= 1'b0;
      key_q        <= '0;
      op_q         <= 1'b0;
      status_q     <= StatusOk;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wvalid_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_q <= sweep_q + 1'b1;  // wraps back to 0 after the last index
          if (&sweep_q) begin
            free_q       <= '1;
            free_count_q <= (ADDR_WIDTH + 1)'(ADDR_DEPTH);
            init_done_q  <= 1'b1;
          end
        end
        StIdle: begin
          if (flush_req) begin
            init_done_q <= 1'b0;
            sweep_q     <= '0;
          end else if (req_valid) begin
            key_q <= req_data;
            op_q  <= req_op;
          end
        end
        StEval: begin
          we_q     <= 1'b0;
          wvalid_q <= 1'b0;
          addr_q   <= '0;
          if (!op_q) begin
            if (lookup_hit) begin
              status_q <= StatusExists;
              addr_q   <= lookup_addr;
            end else if (free_count_q != '0) begin
              status_q <= StatusOk;
              addr_q   <= alloc_addr;
              we_q     <= 1'b1;
              wvalid_q <= 1'b1;
            end else begin
              status_q <= StatusFull;
            end
          end else if (lookup_hit) begin
            status_q <= StatusOk;
            addr_q   <= lookup_addr;
            we_q     <= 1'b1;
          end else begin
            status_q <= StatusNotFound;
          end
        end
        StDone: begin
          // Bitmap and count follow the write issued this cycle.
          if (we_q) begin
            if (wvalid_q) begin
              free_q[addr_q] <= 1'b0;
              free_count_q   <= free_count_q - 1'b1;
            end else begin
              free_q[addr_q] <= 1'b1;
              free_count_q   <= free_count_q + 1'b1;
            end
          end
          we_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs; held at reset values while reset is asserted.
  always_comb begin
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_status = StatusOk;
    rsp_addr   = '0;
    cam_we     = 1'b0;
    cam_addr   = '0;
    cam_data   = '0;
    cam_valid  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        StInit: begin
          cam_we   = 1'b1;
          cam_addr = sweep_q;
        end
        StIdle: req_ready = !flush_req;
        StDone: begin
          rsp_valid  = 1'b1;
          rsp_status = status_q;
          rsp_addr   = addr_q;
          cam_we     = we_q;
          cam_addr   = addr_q;
          cam_data   = key_q;
          cam_valid  = wvalid_q;
        end
        default: ;
      endcase
    end
  end

  assign lookup_data = key_q;
  assign init_done   = init_done_q;
  assign free_count  = free_count_q;

endmodule

// File: tb/tb_cam_learn_ctrl.sv
module tb_cam_learn_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam logic [1:0] OK = 2'b00, EXISTS = 2'b01, FULL = 2'b10, NOTFOUND = 2'b11;

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, req_op, rsp_valid, init_done;
  logic cam_we, cam_valid, lookup_hit;
  logic [DW-1:0] req_data, cam_data, lookup_data;
  logic [1:0] rsp_status;
  logic [AW-1:0] rsp_addr, cam_addr, lookup_addr;
  logic [AW:0] free_count;
`ifdef CAM_LEARN_FLUSH_EN
  logic flush;
`endif

  always #5 clk = ~clk;

  cam_learn_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
`ifdef CAM_LEARN_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_data(req_data),
    .rsp_valid(rsp_valid),
    .rsp_status(rsp_status),
    .rsp_addr(rsp_addr),
    .free_count(free_count),
    .init_done(init_done),
    .cam_we(cam_we),
    .cam_addr(cam_addr),
    .cam_data(cam_data),
    .cam_valid(cam_valid),
    .lookup_data(lookup_data),
    .lookup_addr(lookup_addr),
    .lookup_hit(lookup_hit)
  );

  // CAM core model: no reset, stale valid entries all holding 0xDEADBEEF,
  // compare result registered one cycle after lookup_data, OR-combined address.
  logic          cam_mem_v [DEPTH] = '{default: 1'b1};
  logic [DW-1:0] cam_mem_d [DEPTH] = '{default: 32'hDEADBEEF};
  always @(posedge clk) begin : cam_core
    logic h;
    logic [AW-1:0] a;
    h = 1'b0;
    a = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cam_mem_v[i] && cam_mem_d[i] == lookup_data) begin
        h = 1'b1;
        a = a | AW'(i);
      end
    end
    lookup_hit  <= h;
    lookup_addr <= a;
    if (cam_we) begin
      cam_mem_v[cam_addr] <= cam_valid;
      cam_mem_d[cam_addr] <= cam_data;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit in_sweep = 1'b1;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Table model: which keys live where, and how many slots remain.
  typedef struct {
    int            cyc;
    logic [1:0]    st;
    logic [AW-1:0] addr;
    bit            we;
    bit            cv;
    logic [DW-1:0] key;
    int            fb;
    int            fa;
  } exp_t;

  bit            m_v [DEPTH];
  logic [DW-1:0] m_k [DEPTH];
  int            m_free;
  exp_t          q[$];

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
    m_free = DEPTH;
  endtask

  task automatic predict(input bit op, input logic [DW-1:0] key, output exp_t e);
    int hit;
    int slot;
    hit = -1;
    for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_k[i] == key) hit = i;
    e = '{default: 0};
    e.key = key;
    e.fb = m_free;
    if (!op) begin
      if (hit >= 0) begin
        e.st = EXISTS;
        e.addr = AW'(hit);
      end else if (m_free > 0) begin
        slot = -1;
        for (int i = DEPTH - 1; i >= 0; i--) if (!m_v[i]) slot = i;
        e.st = OK;
        e.addr = AW'(slot);
        e.we = 1'b1;
        e.cv = 1'b1;
        m_v[slot] = 1'b1;
        m_k[slot] = key;
        m_free--;
      end else begin
        e.st = FULL;
      end
    end else if (hit >= 0) begin
      e.st = OK;
      e.addr = AW'(hit);
      e.we = 1'b1;
      m_v[hit] = 1'b0;
      m_free++;
    end else begin
      e.st = NOTFOUND;
    end
    e.fa = m_free;
  endtask

  // Per-cycle compare against the model's response queue.
  exp_t ce;
  int   free_chk_cyc = -1;
  int   free_chk_val = 0;
  always @(negedge clk) begin
    #2;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ce = q.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_status", rsp_status, ce.st);
      chk("rsp_addr", rsp_addr, ce.addr);
      chk("cam_we", cam_we, ce.we);
      if (ce.we) begin
        chk("cam_addr", cam_addr, ce.addr);
        chk("cam_valid", cam_valid, ce.cv);
        chk("cam_data", cam_data, ce.key);
      end
      chk("free_count during DONE", free_count, ce.fb);
      free_chk_cyc = cyc + 1;
      free_chk_val = ce.fa;
    end else begin
      chk("rsp_valid idle", rsp_valid, 0);
      if (!in_sweep) chk("cam_we idle", cam_we, 0);
    end
    if (free_chk_cyc == cyc) chk("free_count after DONE", free_count, free_chk_val);
  end

  // Entered in the first sweep cycle.
  task automatic check_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      if (i > 0) step();
      chk("sweep cam_we", cam_we, 1);
      chk("sweep cam_addr", cam_addr, i);
      chk("sweep cam_valid", cam_valid, 0);
      chk("sweep req_ready", req_ready, 0);
    end
    step();
    chk("post-sweep req_ready", req_ready, 1);
    chk("post-sweep init_done", init_done, 1);
    chk("post-sweep free_count", free_count, DEPTH);
    in_sweep = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    req_valid = 1'b0;
    in_sweep = 1'b1;
    q.delete();
    free_chk_cyc = -1;
    model_clear();
    repeat (hold) step();
    chk("reset req_ready", req_ready, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset cam_we", cam_we, 0);
    chk("reset init_done", init_done, 0);
    chk("reset free_count", free_count, DEPTH);
    chk("reset lookup_data", lookup_data, 0);
    reset = 1'b0;
    #1;
    check_sweep();
  endtask

  task automatic do_req(input bit op, input logic [DW-1:0] key, output exp_t e);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    chk("req_ready wait", req_ready, 1);
    e = '{default: 0};
    if (!req_ready) return;
    predict(op, key, e);
    e.cyc = cyc + 3;
    q.push_back(e);
    req_valid = 1'b1;
    req_op = op;
    req_data = key;
    step();
    req_valid = 1'b0;
    req_data = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() > 0 || !req_ready) && n < 50) begin
      step();
      n++;
    end
    chk("idle wait timeout", (q.size() == 0 && req_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  exp_t e;
  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 1'b0;
    req_data = '0;
`ifdef CAM_LEARN_FLUSH_EN
    flush = 1'b0;
`endif
    do_reset(2);

    do_req(0, 32'hDEADBEEF, e);
    chk("model insert status", e.st, OK);
    chk("model insert addr", e.addr, 0);
    do_req(0, 32'hDEADBEEF, e);
    chk("model repeat status", e.st, EXISTS);
    wait_idle();
    chk("free after first insert", free_count, 31);

    for (int i = 1; i < DEPTH; i++) begin
      do_req(0, 32'h1000 + i, e);
      if (i == 17) chk("model addr 17", e.addr, 17);
    end
    do_req(0, 32'h2000_0000, e);
    chk("model full status", e.st, FULL);
    wait_idle();
    chk("free when full", free_count, 0);

    do_req(1, 32'h1005, e);
    chk("model delete addr", e.addr, 5);
    wait_idle();
    chk("free after delete", free_count, 1);
    do_req(0, 32'hCAFE0001, e);
    chk("model reuse addr", e.addr, 5);
    do_req(1, 32'hABCDABCD, e);
    chk("model notfound status", e.st, NOTFOUND);
    do_req(1, 32'hDEADBEEF, e);
    do_req(0, 32'h0BADF00D, e);
    wait_idle();
    chk("free after churn", free_count, 0);

    // Reset during EVAL: no response, sweep restarts at index 0.
    req_valid = 1'b1;
    req_op = 1'b0;
    req_data = 32'h5555AAAA;
    step();
    req_valid = 1'b0;
    step();
    do_reset(1);
    do_req(0, 32'h1003, e);
    chk("model insert after reset", e.addr, 0);
    wait_idle();

`ifdef CAM_LEARN_FLUSH_EN
    flush = 1'b1;
    req_valid = 1'b1;
    req_op = 1'b0;
    req_data = 32'h7777;
    in_sweep = 1'b1;
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    model_clear();
    chk("flush init_done low", init_done, 0);
    check_sweep();
    do_req(0, 32'h1003, e);
    wait_idle();
    chk("free after flush insert", free_count, 31);
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
